tmr_cfg_scrubber: RTL

- Holds NUM_REGS triplicated 6-bit configuration words.
- Serves bitwise-majority-voted read data to the PLL/readout logic.
- A background scrub FSM walks every address, detects copy disagreement (SEU) and rewrites all three copies with the voted value.
- Sits between the slow-control register bus and the PLL configuration consumers; supplies SEU statistics to status registers.

---
 rtl/tmr_cfg_scrubber_pkg.sv | 30 +++
 rtl/tmr_cfg_scrubber_if.sv | 39 +++
 rtl/tmr_cfg_scrubber_maj_vote6.sv | 18 +
 rtl/tmr_cfg_scrubber.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_cfg_scrubber_pkg.sv
// -----------------------------------------------------------------------------
// tmr_cfg_pkg
// Shared definitions for the triplicated configuration store:
//   CFG_W          width of one configuration word
//   COPY_A/B/C     copy-select codes used on the injection port
//   scrub_state_e  scrub sequencer state encoding
//   maj3           bitwise two-out-of-three majority of three words
// -----------------------------------------------------------------------------
package tmr_cfg_pkg;

    localparam int CFG_W = 6;

    localparam logic [1:0] COPY_A = 2'd0;
    localparam logic [1:0] COPY_B = 2'd1;
    localparam logic [1:0] COPY_C = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CHECK = 2'd2,
        ST_FIX   = 2'd3
    } scrub_state_e;

    function automatic logic [CFG_W-1:0] maj3(input logic [CFG_W-1:0] a,
                                              input logic [CFG_W-1:0] b,
                                              input logic [CFG_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_cfg_scrubber_if.sv
// -----------------------------------------------------------------------------
// tmr_cfg_scrubber_if
// Slow-control host port of the triplicated configuration store.
//   wr_en    host write strobe
//   wr_addr  host write address
//   wr_data  host write data (goes to all three copies)
//   rd_addr  read address
//   rd_data  voted word at rd_addr, combinational
// Modports: master = host / readout side, slave = scrubber.
// -----------------------------------------------------------------------------
interface tmr_cfg_scrubber_if
    import tmr_cfg_pkg::*;
#(
    parameter int ADDR_W = 3
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CFG_W-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [CFG_W-1:0]  rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/tmr_cfg_scrubber_maj_vote6.sv
// -----------------------------------------------------------------------------
// maj_vote6
// Combinational bitwise majority of three configuration words.
//   a_i, b_i, c_i  the three copies
//   q_o            per-bit two-out-of-three vote
// -----------------------------------------------------------------------------
module maj_vote6
    import tmr_cfg_pkg::*;
(
    input  logic [CFG_W-1:0] a_i,
    input  logic [CFG_W-1:0] b_i,
    input  logic [CFG_W-1:0] c_i,
    output logic [CFG_W-1:0] q_o
);

    assign q_o = maj3(a_i, b_i, c_i);

endmodule

// File: rtl/tmr_cfg_scrubber.sv
// -----------------------------------------------------------------------------
// tmr_cfg_scrubber
// NUM_REGS triplicated configuration words with majority-voted readout and a
// background scrubber that rewrites any word whose copies disagree.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   bus             host write / voted read port (tmr_cfg_scrubber_if.slave)
//   scrub_en        enables periodic scrub steps
//   inj_en/addr/copy/mask  test upset injection: XOR mask into one copy
//   err_clr         clears err_cnt
//   err_cnt         saturating count of corrected words
//   err_pulse       one-cycle pulse per correction (cycle after FIX)
//   err_addr        address of the last correction
//   scrub_busy      high while the sequencer is in FETCH/CHECK/FIX
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | count down the step timer while scrub_en is high
// FETCH  | latch the three copies at the pointer into shadow registers
// CHECK  | vote the shadows; go to FIX on any disagreement, else advance
// FIX    | write the vote back to all copies, log it, advance the pointer
// -----------------------------------------------------------------------------
module tmr_cfg_scrubber
    import tmr_cfg_pkg::*;
#(
    parameter int NUM_REGS     = 8,
    parameter int ADDR_W       = 3,
    parameter int SCRUB_PERIOD = 1024,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    tmr_cfg_scrubber_if.slave bus,
    input  logic              scrub_en,
    input  logic              inj_en,
    input  logic [ADDR_W-1:0] inj_addr,
    input  logic [1:0]        inj_copy,
    input  logic [CFG_W-1:0]  inj_mask,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_pulse,
    output logic [ADDR_W-1:0] err_addr,
    output logic              scrub_busy
);

    localparam int                TMR_W      = $clog2(SCRUB_PERIOD);
    localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(SCRUB_PERIOD - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST   = ADDR_W'(NUM_REGS - 1);

    logic [CFG_W-1:0]  mem_a_q [NUM_REGS];
    logic [CFG_W-1:0]  mem_b_q [NUM_REGS];
    logic [CFG_W-1:0]  mem_c_q [NUM_REGS];

    scrub_state_e      state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    logic              abort_q, abort_d;
    logic [CFG_W-1:0]  sh_a_q, sh_b_q, sh_c_q;

    logic [CNT_W-1:0]  err_cnt_q;
    logic              err_pulse_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic [CFG_W-1:0]  rd_a, rd_b, rd_c, rd_vote;
    logic [CFG_W-1:0]  pt_a, pt_b, pt_c;
    logic [CFG_W-1:0]  chk_vote;
    logic              mismatch;
    logic              wr_hit_ptr;
    logic              abort_now;
    logic [ADDR_W-1:0] ptr_next;
    logic              fix_we;
    logic              commit;

    // Read and pointer muxes compare against each valid index, so any
    // address at or beyond NUM_REGS selects all-zero copies and votes 0.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        rd_c = '0;
        pt_a = '0;
        pt_b = '0;
        pt_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_addr == ADDR_W'(i)) begin
                rd_a = mem_a_q[i];
                rd_b = mem_b_q[i];
                rd_c = mem_c_q[i];
            end
            if (ptr_q == ADDR_W'(i)) begin
                pt_a = mem_a_q[i];
                pt_b = mem_b_q[i];
                pt_c = mem_c_q[i];
            end
        end
    end

    maj_vote6 u_rd_vote (
        .a_i (rd_a),
        .b_i (rd_b),
        .c_i (rd_c),
        .q_o (rd_vote)
    );

    assign bus.rd_data = rd_vote;

    // Shadows stay frozen through CHECK and FIX, so this vote is also the
    // writeback value in FIX.
    maj_vote6 u_chk_vote (
        .a_i (sh_a_q),
        .b_i (sh_b_q),
        .c_i (sh_c_q),
        .q_o (chk_vote)
    );

    assign mismatch   = (sh_a_q != chk_vote) || (sh_b_q != chk_vote) ||
                        (sh_c_q != chk_vote);
    assign wr_hit_ptr = bus.wr_en && (bus.wr_addr == ptr_q);
    // A host write to the word under inspection makes the shadows stale;
    // the host value is authoritative, so the correction is abandoned.
    assign abort_now  = abort_q || wr_hit_ptr;
    assign ptr_next   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        abort_d = abort_q;
        fix_we  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (!scrub_en) begin
                    timer_d = TMR_RELOAD;
                end else if (timer_q == '0) begin
                    timer_d = TMR_RELOAD;
                    state_d = ST_FETCH;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_FETCH: begin
                abort_d = wr_hit_ptr;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch && !abort_now) begin
                    state_d = ST_FIX;
                end else begin
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end
            end
            ST_FIX: begin
                ptr_d   = ptr_next;
                state_d = ST_IDLE;
                if (!wr_hit_ptr) begin
                    fix_we = 1'b1;
                    commit = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage write priority: host write, then scrub writeback, then
    // injection. A lower-priority operation at the same address is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
                mem_c_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) begin
                    mem_a_q[i] <= bus.wr_data;
                    mem_b_q[i] <= bus.wr_data;
                    mem_c_q[i] <= bus.wr_data;
                end else if (fix_we && (ptr_q == ADDR_W'(i))) begin
                    mem_a_q[i] <= chk_vote;
                    mem_b_q[i] <= chk_vote;
                    mem_c_q[i] <= chk_vote;
                end else if (inj_en && (inj_addr == ADDR_W'(i))) begin
                    case (inj_copy)
                        COPY_A:  mem_a_q[i] <= mem_a_q[i] ^ inj_mask;
                        COPY_B:  mem_b_q[i] <= mem_b_q[i] ^ inj_mask;
                        COPY_C:  mem_c_q[i] <= mem_c_q[i] ^ inj_mask;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= TMR_RELOAD;
            ptr_q       <= '0;
            abort_q     <= 1'b0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            sh_c_q      <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ptr_q       <= ptr_d;
            abort_q     <= abort_d;
            err_pulse_q <= commit;
            if (state_q == ST_FETCH) begin
                sh_a_q <= pt_a;
                sh_b_q <= pt_b;
                sh_c_q <= pt_c;
            end
            if (commit) begin
                err_addr_q <= ptr_q;
            end
            // Clear wins over a coincident increment.
            if (err_clr) begin
                err_cnt_q <= '0;
            end else if (commit && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign err_cnt    = err_cnt_q;
    assign err_pulse  = err_pulse_q;
    assign err_addr   = err_addr_q;
    assign scrub_busy = (state_q != ST_IDLE);

endmodule
